// File: rtl/mem_ctrl_defs_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_ctrl_defs (package)
// Description : Shared definitions for the MEM-stage access sequencer:
//               sequencer state encoding, default timeout and the data value
//               returned to the pipeline when an access is aborted.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_ctrl_defs;

  // Sequencer states. DONE is a single cycle in which the pipeline advances,
  // so the same MEM-stage instruction can never be issued twice.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Default number of BUSY cycles to wait for mem_ack before aborting.
  localparam int C_DEFAULT_TIMEOUT = 16;

  // Load data presented to writeback after an aborted access.
  localparam int unsigned C_ERR_DATA = 0;

endpackage : mem_ctrl_defs
`default_nettype wire

// File: rtl/mem_timeout_ctr.sv
`default_nettype none
// ============================================================================
// Module      : mem_timeout_ctr
// Description : Clear/enable up-counter with a terminal-count flag. tc is
//               high while the count equals TERMINAL-1; the owner stops
//               enabling the counter at that point, so it never wraps.
// Ports       : clk, rst (async, active-high)
//               clr  - synchronous clear to zero (has priority over en)
//               en   - increment enable
//               tc   - terminal count reached (combinational from the count)
// Revision    : 1.0 - initial release
// ============================================================================
module mem_timeout_ctr #(
  parameter int TERMINAL = 16,
  parameter int CNT_W    = $clog2(TERMINAL) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (en) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign tc = (r_count == CNT_W'(TERMINAL - 1));

endmodule : mem_timeout_ctr
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_access_ctrl
// Description : MEM-stage sequencer for the 5-stage MIPS core. Turns a
//               load/store in MEM into a req/ack transaction to data memory,
//               freezes the upstream pipeline registers while it is
//               outstanding, bubbles MEM/WB during the freeze, and aborts
//               with a sticky bus error if no ack arrives in time.
// Ports       : clk, rst (async, active-high)
//               MemReadM/MemWriteM/AluoutM/WriteDataM - MEM-stage request
//               err_clr                - synchronous clear of bus_err
//               mem_req/mem_we/mem_addr/mem_wdata - registered memory request
//               mem_ack/mem_rdata      - memory completion and read data
//               ReadDataM              - registered load data to MEM/WB
//               StallPipe              - hold PC, IF/ID, ID/EX, EX/MEM
//               FlushW                 - bubble into MEM/WB
//               bus_err                - sticky timeout flag
// Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
  import mem_ctrl_defs::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = C_DEFAULT_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemReadM,
  input  logic              MemWriteM,
  input  logic [ADDR_W-1:0] AluoutM,
  input  logic [DATA_W-1:0] WriteDataM,
  input  logic              err_clr,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              StallPipe,
  output logic              FlushW,
  output logic              bus_err
);

  state_t r_state;
  state_t w_nextState;

  logic              w_access;
  logic              w_tc;
  logic              w_ctrClr;
  logic              w_ctrEn;
  logic              w_errSet;
  logic              w_nextReq;
  logic              w_nextWe;
  logic [ADDR_W-1:0] w_nextAddr;
  logic [DATA_W-1:0] w_nextWdata;
  logic [DATA_W-1:0] w_nextRdata;
  logic              w_nextErr;

  assign w_access = MemReadM | MemWriteM;

  mem_timeout_ctr #(
    .TERMINAL (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk (clk),
    .rst (rst),
    .clr (w_ctrClr),
    .en  (w_ctrEn),
    .tc  (w_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      ReadDataM <= '0;
      bus_err   <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      mem_req   <= w_nextReq;
      mem_we    <= w_nextWe;
      mem_addr  <= w_nextAddr;
      mem_wdata <= w_nextWdata;
      ReadDataM <= w_nextRdata;
      bus_err   <= w_nextErr;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_nextReq   = mem_req;
    w_nextWe    = mem_we;
    w_nextAddr  = mem_addr;
    w_nextWdata = mem_wdata;
    w_nextRdata = ReadDataM;
    w_errSet    = 1'b0;
    w_ctrClr    = 1'b0;
    w_ctrEn     = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_access) begin
          w_nextState = BUSY;
          w_nextReq   = 1'b1;
          // A simultaneous read+write request is treated as a write.
          w_nextWe    = MemWriteM;
          w_nextAddr  = AluoutM;
          w_nextWdata = WriteDataM;
          w_ctrClr    = 1'b1;
        end
      end

      BUSY: begin
        // Ack is tested before the timeout so a late-but-legal ack wins.
        if (mem_ack) begin
          if (!mem_we) begin
            w_nextRdata = mem_rdata;
          end
          w_nextReq   = 1'b0;
          w_nextState = DONE;
        end else if (w_tc) begin
          w_nextReq   = 1'b0;
          w_nextRdata = DATA_W'(C_ERR_DATA);
          w_errSet    = 1'b1;
          w_nextState = DONE;
        end else begin
          w_ctrEn = 1'b1;
        end
      end

      DONE: begin
        w_nextState = IDLE;
      end

      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // A new error in the same cycle as a clear request keeps the flag set.
  assign w_nextErr = w_errSet | (bus_err & ~err_clr);

  // The IDLE term stalls in the cycle the request is being latched, so the
  // instruction stays in MEM until its access completes.
  assign StallPipe = ((r_state == IDLE) & w_access) | (r_state == BUSY);
  assign FlushW    = StallPipe;

endmodule : mem_access_ctrl
`default_nettype wire
